// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  FULL_MASK      = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  typedef enum logic {
    FETCH = GNT_FETCH,
    DATA  = GNT_DATA
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side handshake bundle of the arbiter.
// slave is the arbiter's view; master is the hart/memory environment's view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_ready;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;

  logic        i_d_req;
  logic        i_d_wen;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [3:0]  i_d_mask;
  logic        o_d_ready;
  logic        o_d_valid;
  logic [31:0] o_d_rdata;

  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_valid;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ready, o_if_valid, o_if_rdata,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output o_d_ready, o_d_valid, o_d_rdata,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_valid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ready, o_if_valid, o_if_rdata,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  o_d_ready, o_d_valid, o_d_rdata,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_valid, i_mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the side that did not win last time wins.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic   req_fetch,
  input  logic   req_data,
  input  grant_t last_grant,
  output logic   gnt_valid,
  output grant_t gnt
);

  // pick the winner; a tie goes to whoever was not granted last
  always_comb begin
    gnt_valid = req_fetch | req_data;
    gnt       = FETCH;
    if (req_fetch && req_data) begin
      gnt = (last_grant == FETCH) ? DATA : FETCH;
    end else if (req_data) begin
      gnt = DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes the fetch and data requesters onto one multi-cycle memory port,
// one transaction outstanding at a time.
//
// state | meaning
// IDLE  | waiting for a request; the winner is accepted and latched here
// ISSUE | o_mem_req high from the latched transaction until i_mem_ready
// WAIT  | accepted by memory, waiting for i_mem_valid
// RESP  | one-cycle response pulse to the granted side
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  state_t      state_q, state_d;
  grant_t      last_grant_q;
  grant_t      side_q;
  grant_t      gnt;
  logic        gnt_valid;
  logic        accept;
  logic        capture;

  logic        txn_wen_q;
  logic [31:0] txn_addr_q;
  logic [31:0] txn_wdata_q;
  logic [3:0]  txn_mask_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  rr_arb2 u_rr_arb2 (
    .req_fetch  (bus.i_if_req),
    .req_data   (bus.i_d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // next-state, accept and capture decode
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_mem_ready) begin
          if (bus.i_mem_valid) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.i_mem_valid) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, fairness pointer and the side that owns the outstanding transaction
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= FETCH;
      side_q       <= FETCH;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gnt;
        side_q       <= gnt;
      end
    end
  end

  // transaction register: holds the downstream fields stable while issuing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      txn_wen_q   <= 1'b0;
      txn_addr_q  <= '0;
      txn_wdata_q <= '0;
      txn_mask_q  <= '0;
    end else if (accept) begin
      if (gnt == DATA) begin
        txn_wen_q   <= bus.i_d_wen;
        txn_addr_q  <= bus.i_d_addr & WORD_ADDR_MASK;
        txn_wdata_q <= bus.i_d_wdata;
        txn_mask_q  <= bus.i_d_mask;
      end else begin
        txn_wen_q   <= 1'b0;
        txn_addr_q  <= bus.i_if_addr & WORD_ADDR_MASK;
        txn_wdata_q <= '0;
        txn_mask_q  <= FULL_MASK;
      end
    end
  end

  // response capture; the side not being served keeps its last word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (capture) begin
      if (side_q == FETCH) begin
        if_rdata_q <= bus.i_mem_rdata;
      end else begin
        d_rdata_q  <= bus.i_mem_rdata;
      end
    end
  end

  // ready is gated by reset so it reads 0 while reset is held
  assign bus.o_if_ready  = i_rst_n & accept & (gnt == FETCH);
  assign bus.o_d_ready   = i_rst_n & accept & (gnt == DATA);
  assign bus.o_if_valid  = (state_q == RESP) && (side_q == FETCH);
  assign bus.o_d_valid   = (state_q == RESP) && (side_q == DATA);
  assign bus.o_if_rdata  = if_rdata_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_mem_req   = (state_q == ISSUE);
  assign bus.o_mem_wen   = txn_wen_q;
  assign bus.o_mem_addr  = txn_addr_q;
  assign bus.o_mem_wdata = txn_wdata_q;
  assign bus.o_mem_mask  = txn_mask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the bench plays both the hart requesters and the memory.
module tb_mem_arbiter;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_fails;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.i_if_req    = 1'b0;
    bus.i_if_addr   = '0;
    bus.i_d_req     = 1'b0;
    bus.i_d_wen     = 1'b0;
    bus.i_d_addr    = '0;
    bus.i_d_wdata   = '0;
    bus.i_d_mask    = '0;
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        exp_d;
    logic [31:0] k;
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    i_rst_n = 1'b0;
    #1;
    chk("rst_if_ready", bus.o_if_ready, 0);
    chk("rst_d_ready",  bus.o_d_ready,  0);
    chk("rst_if_valid", bus.o_if_valid, 0);
    chk("rst_d_valid",  bus.o_d_valid,  0);
    chk("rst_mem_req",  bus.o_mem_req,  0);
    chk("rst_mem_wen",  bus.o_mem_wen,  0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    chk("rst_mem_mask", bus.o_mem_mask, 0);
    chk("rst_if_rdata", bus.o_if_rdata, 0);
    do_reset();

    // fetch only: ready in cycle 1, valid in cycle 3, response in cycle 4
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h100;
    #1;
    chk("f_if_ready_c0", bus.o_if_ready, 1);
    chk("f_d_ready_c0",  bus.o_d_ready,  0);
    step();
    bus.i_if_req = 1'b0;
    chk("f_mem_req_c1",  bus.o_mem_req,  1);
    chk("f_mem_addr_c1", bus.o_mem_addr, 32'h100);
    chk("f_mem_mask_c1", bus.o_mem_mask, 4'b1111);
    chk("f_mem_wen_c1",  bus.o_mem_wen,  0);
    chk("f_if_ready_c1", bus.o_if_ready, 0);
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_mem_ready = 1'b0;
    chk("f_mem_req_c2",  bus.o_mem_req,  0);
    step();
    chk("f_if_valid_c3", bus.o_if_valid, 0);
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hDEADBEEF;
    step();
    bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
    chk("f_if_valid_c4", bus.o_if_valid, 1);
    chk("f_if_rdata_c4", bus.o_if_rdata, 32'hDEADBEEF);
    chk("f_d_valid_c4",  bus.o_d_valid,  0);
    step();
    chk("f_if_valid_c5", bus.o_if_valid, 0);
    chk("f_if_rdata_hold", bus.o_if_rdata, 32'hDEADBEEF);

    // simultaneous requests after reset, same-cycle ready+valid every time
    do_reset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h200;
    bus.i_d_req   = 1'b1;
    bus.i_d_wen   = 1'b0;
    bus.i_d_addr  = 32'h300;
    bus.i_d_mask  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_d = (i % 2 == 0);
      k     = 32'hA000_0000 + i;
      #1;
      chk("rr_d_ready",  bus.o_d_ready,  exp_d);
      chk("rr_if_ready", bus.o_if_ready, !exp_d);
      step();
      chk("rr_mem_req",  bus.o_mem_req,  1);
      chk("rr_mem_addr", bus.o_mem_addr, exp_d ? 32'h300 : 32'h200);
      bus.i_mem_ready = 1'b1;
      bus.i_mem_valid = 1'b1;
      bus.i_mem_rdata = k;
      step();
      bus.i_mem_ready = 1'b0;
      bus.i_mem_valid = 1'b0;
      chk("rr_d_valid",    bus.o_d_valid,  exp_d);
      chk("rr_if_valid",   bus.o_if_valid, !exp_d);
      chk("rr_rdata",      exp_d ? bus.o_d_rdata : bus.o_if_rdata, k);
      chk("rr_mem_req_rs", bus.o_mem_req,  0);
      chk("rr_no_ready_rs", {31'b0, bus.o_if_ready | bus.o_d_ready}, 0);
      step();
    end
    idle_inputs();
    step();

    // store held through 3 cycles of back-pressure
    bus.i_d_req   = 1'b1;
    bus.i_d_wen   = 1'b1;
    bus.i_d_addr  = 32'h2003;
    bus.i_d_mask  = 4'b1000;
    bus.i_d_wdata = 32'hAB00_0000;
    #1;
    chk("st_d_ready", bus.o_d_ready, 1);
    step();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      chk("st_mem_req",   bus.o_mem_req,   1);
      chk("st_mem_addr",  bus.o_mem_addr,  32'h2000);
      chk("st_mem_wen",   bus.o_mem_wen,   1);
      chk("st_mem_mask",  bus.o_mem_mask,  4'b1000);
      chk("st_mem_wdata", bus.o_mem_wdata, 32'hAB00_0000);
      if (c == 3) bus.i_mem_ready = 1'b1;
      step();
    end
    bus.i_mem_ready = 1'b0;
    chk("st_wait_mem_req", bus.o_mem_req, 0);
    chk("st_d_valid_wait", bus.o_d_valid, 0);
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h55;
    step();
    bus.i_mem_valid = 1'b0;
    chk("st_d_valid",   bus.o_d_valid, 1);
    step();
    chk("st_d_valid_once", bus.o_d_valid, 0);

    // asynchronous reset while in WAIT
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h400;
    #1;
    chk("ar_if_ready", bus.o_if_ready, 1);
    step();
    bus.i_if_req    = 1'b0;
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_mem_ready = 1'b0;
    chk("ar_in_wait", bus.o_mem_req, 0);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("ar_mem_addr", bus.o_mem_addr, 0);
    chk("ar_mem_mask", bus.o_mem_mask, 0);
    chk("ar_if_rdata", bus.o_if_rdata, 0);
    chk("ar_d_rdata",  bus.o_d_rdata,  0);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hBAD0_BAD0;
    step();
    bus.i_mem_valid = 1'b0;
    chk("ar_if_valid", bus.o_if_valid, 0);
    chk("ar_d_valid",  bus.o_d_valid,  0);
    step();
    chk("ar_if_valid2", bus.o_if_valid, 0);
    chk("ar_if_rdata2", bus.o_if_rdata, 0);

    // spurious memory response in IDLE, then a clean fetch
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hFFFF_0000;
    step();
    bus.i_mem_valid = 1'b0;
    chk("sp_if_valid", bus.o_if_valid, 0);
    chk("sp_d_valid",  bus.o_d_valid,  0);
    chk("sp_mem_req",  bus.o_mem_req,  0);
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h500;
    #1;
    chk("sp_if_ready", bus.o_if_ready, 1);
    step();
    bus.i_if_req = 1'b0;
    chk("sp_mem_addr", bus.o_mem_addr, 32'h500);
    bus.i_mem_ready = 1'b1;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h1234_5678;
    step();
    idle_inputs();
    chk("sp_fetch_valid", bus.o_if_valid, 1);
    chk("sp_fetch_rdata", bus.o_if_rdata, 32'h1234_5678);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
